// File: rtl/sd_block_fetch.sv
// Fetches one block from the backing-store bus into the sd_phy read buffer, then pulses block_read_go.
// Optional macro BLOCK_FETCH_BYTESWAP_EN byte-reverses each fetched word for the MSB-first phy.
//  state | meaning
//  IDLE  | waiting for a rising edge on block_read_act
//  REQ   | one bus read in flight; mem_req raised the cycle after entry
//  WAIT  | bus idle for one cycle; also lets the final zero-fill write land
//  ZERO  | out-of-range block: write zero to every buffer word
//  DONE  | one-cycle block_read_go
module sd_block_fetch #(
    parameter int unsigned WORDS      = 128,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] MAX_BLOCKS = 32'd65536
) (
    input  logic                       clk_50,
    input  logic                       reset_n,
    input  logic                       block_read_act,
    input  logic [31:0]                block_read_addr,
    input  logic                       block_read_stop,
    output logic                       block_read_go,
    output logic                       err_out_range,
    output logic                       busy,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_ack,
    input  logic [31:0]                mem_rdata,
    output logic [$clog2(WORDS)-1:0]   bram_wr_addr,
    output logic [31:0]                bram_wr_data,
    output logic                       bram_wr_en
);

    localparam int unsigned AW = $clog2(WORDS);
    localparam logic [AW-1:0] WC_LAST = AW'(WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ZERO, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            act_q;
    logic [31:0]     blk_q, blk_d;
    logic [AW-1:0]   wc_q, wc_d;
    logic            mem_req_q, mem_req_d;
    logic            err_q, err_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [31:0]     rdata_fmt;

    logic start, ack_ok, wc_last, out_range;
    assign start     = block_read_act & ~act_q;
    assign ack_ok    = mem_req_q & mem_ack;
    assign wc_last   = (wc_q == WC_LAST);
    assign out_range = (block_read_addr >= MAX_BLOCKS);

`ifdef BLOCK_FETCH_BYTESWAP_EN
    assign rdata_fmt = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
`else
    assign rdata_fmt = mem_rdata;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            act_q     <= 1'b0;
            blk_q     <= '0;
            wc_q      <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            act_q     <= block_read_act;
            blk_q     <= blk_d;
            wc_q      <= wc_d;
            mem_req_q <= mem_req_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = out_range ? S_ZERO : S_REQ;
            S_REQ: begin
                if (block_read_stop) state_d = S_IDLE;
                else if (ack_ok)     state_d = S_WAIT;
            end
            S_WAIT: begin
                if (block_read_stop) state_d = S_IDLE;
                else if (wc_last)    state_d = S_DONE;
                else                 state_d = S_REQ;
            end
            // Last zero write passes through WAIT so it commits before the go pulse.
            S_ZERO: begin
                if (block_read_stop) state_d = S_IDLE;
                else if (wc_last)    state_d = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_d     = blk_q;
        wc_d      = wc_q;
        mem_req_d = 1'b0;
        err_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d = block_read_addr;
                    wc_d  = '0;
                    err_d = out_range;
                end
            end
            S_REQ: begin
                // An ack coinciding with stop still completes its buffer write.
                if (ack_ok) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wc_q;
                    wr_data_d = rdata_fmt;
                end
                mem_req_d = ~ack_ok & ~block_read_stop;
            end
            S_WAIT: begin
                if (!block_read_stop && !wc_last) wc_d = wc_q + AW'(1);
            end
            S_ZERO: begin
                if (!block_read_stop) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wc_q;
                    wr_data_d = '0;
                    if (!wc_last) wc_d = wc_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        block_read_go = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        err_out_range = err_q;
        mem_req       = mem_req_q;
        mem_addr      = mem_req_q ? (BASE_ADDR + (blk_q << 9) + {{(30 - AW){1'b0}}, wc_q, 2'b00}) : 32'h0;
        bram_wr_en    = wr_en_q;
        bram_wr_addr  = wr_addr_q;
        bram_wr_data  = wr_data_q;
    end

endmodule

// File: doc/sd_block_fetch.md
Name: sd_block_fetch

Overview:
- Sits downstream of sd_link's block-read request outputs and upstream of the sd_phy read BRAM.
- On each read request, fetches one 512-byte block (128 x 32-bit words) from a backing-store bus into the read buffer, then pulses block_read_go so the link or phy can start data-out.
- Handles abort on stop and out-of-range blocks.

Parameters:
- WORDS, 128, words per block; power of two; sets the BRAM address width to log2(WORDS).
- BASE_ADDR, 32'h0000_0000, byte base address of the card image on the backing bus.
- MAX_BLOCKS, 32'd65536, number of valid blocks; block indices >= MAX_BLOCKS are out of range.

Ports:
- clk_50  in  1  sole clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- block_read_act  in  1  level from sd_link; a rising edge requests a fetch.
- block_read_addr  in  32  block index, sampled on the act rising edge.
- block_read_stop  in  1  abort the in-flight fetch.
- block_read_go  out  1  one-cycle pulse: block is complete in the BRAM.
- err_out_range  out  1  one-cycle pulse: the requested block is out of range.
- busy  out  1  high while a fetch is in progress.
- mem_req  out  1  read request to the backing store.
- mem_addr  out  32  byte address of the word requested.
- mem_ack  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read data.
- bram_wr_addr  out  7  read-buffer word address (log2(WORDS) bits).
- bram_wr_data  out  32  read-buffer write data.
- bram_wr_en  out  1  read-buffer write strobe.

Behaviour:
- Reset: all outputs 0; state IDLE; act edge detector cleared to 0.
- Request detect: act_q <= block_read_act each cycle; start = block_read_act & ~act_q.
  - start is evaluated only in IDLE.
  - A start seen in any other state is dropped. No queueing.
- States: IDLE, REQ, WAIT, ZERO, DONE.
- IDLE, on start:
  - Latch blk = block_read_addr; clear word counter wc.
  - If blk >= MAX_BLOCKS: pulse err_out_range next cycle and go to ZERO.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1; mem_addr = BASE_ADDR + (blk << 9) + (wc << 2), 32-bit wrap-around, carries discarded.
  - Hold mem_req and mem_addr stable until mem_ack.
  - On mem_ack: register mem_rdata into bram_wr_data, wc into bram_wr_addr; bram_wr_en = 1 in the following cycle; go to WAIT.
- WAIT: mem_req = 0 for exactly one cycle (one outstanding request, no pipelining).
  - If wc == WORDS-1 → DONE.
  - Otherwise wc++ → REQ.
- ZERO: write 0 to each BRAM word, one per cycle (WORDS cycles, no mem_req), then DONE. An out-of-range read still completes, with zero data.
- DONE: block_read_go = 1 for one cycle; go to IDLE.
- busy = 1 in every state except IDLE.
- BRAM write timing: bram_wr_en is registered and lags the corresponding mem_ack by exactly one cycle.
  - The final write lands the cycle before block_read_go.
  - Guaranteed ordering: the last write commits before the go pulse.
- Minimum fetch latency: 3 cycles per word with zero-wait mem_ack (REQ, ack, WAIT), so 384 cycles + 1 (DONE) from start to go.
- block_read_stop, in REQ/WAIT/ZERO:
  - Enter IDLE next cycle; mem_req drops.
  - No go pulse; no err pulse beyond any already issued.
  - A write already registered still completes.
  - If stop and mem_ack coincide in REQ: the ack is consumed (bus transaction complete), the data write proceeds, and then IDLE.
- Stop and start in the same IDLE cycle: start wins (stop in IDLE is ignored).
- Reset mid-fetch: immediate return to IDLE; mem_req drops asynchronously.

Optional Feature:
- BLOCK_FETCH_BYTESWAP_EN:
  - Defined: bram_wr_data = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}, for a little-endian backing bus feeding the MSB-first phy.
  - Undefined: data is passed through unchanged.
  - Zero fill is unaffected either way.

Test Plan:
- Basic fetch: backing store word n = 32'hA5000000 + n, ack on the cycle after each req, act rising with addr=3 → 128 requests at mem_addr 0x600..0x7FC; BRAM word 5 = 0xA5000005; single go pulse; busy falls with go.
- Zero-wait bus: ack tied high → go exactly 385 cycles after start; mem_req low in every WAIT cycle.
- Out of range: MAX_BLOCKS=16, addr=16 → err_out_range pulses once; zero mem_req; 128 BRAM writes of 0; go pulses.
- Abort: stop asserted after the 40th ack → no go; mem_req low the next cycle; ≤41 BRAM writes; a new act edge then restarts from word 0.
- Ignored retrigger: a second act rising edge mid-fetch → no effect; exactly one go.
- Byteswap: with BLOCK_FETCH_BYTESWAP_EN, mem_rdata=32'h11223344 → BRAM holds 32'h44332211; without the macro, BRAM holds 32'h11223344.
